// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the MIPS CPU memory-bus initiator.
package mips_cpu_bus_pkg;

   typedef enum logic [1:0] {
      MemByte = 2'b00,
      MemHalf = 2'b01,
      MemWord = 2'b10,
      MemRsvd = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdCap,
      StWrReq,
      StResp
   } bus_state_t;

   localparam logic [3:0] BYTEEN_NONE = 4'b0000;
   localparam logic [3:0] BYTEEN_B0   = 4'b0001;
   localparam logic [3:0] BYTEEN_LO   = 4'b0011;
   localparam logic [3:0] BYTEEN_HI   = 4'b1100;
   localparam logic [3:0] BYTEEN_ALL  = 4'b1111;

   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_cpu_bus_if.sv
// 32-bit word-addressed memory bus with waitrequest stall.
interface mips_cpu_bus_if;

   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output read,
      output write,
      output byteenable,
      output writedata,
      input  waitrequest,
      input  readdata
   );

   modport slave (
      input  address,
      input  read,
      input  write,
      input  byteenable,
      input  writedata,
      output waitrequest,
      output readdata
   );

endinterface

// File: rtl/mips_cpu_bus_lane.sv
// Lane steering: request-side byteenable/writedata/misalign decode and
// read-side lane extraction with zero or sign extension.
module mips_cpu_bus_lane
   import mips_cpu_bus_pkg::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  byteenable,
   output logic [31:0] wdata_aligned,
   output logic        misalign,
   input  mem_size_t   cap_size,
   input  logic [1:0]  cap_lane,
   input  logic        cap_signed,
   input  logic [31:0] readdata,
   output logic [31:0] rdata_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      byteenable    = BYTEEN_NONE;
      wdata_aligned = wdata;
      misalign      = 1'b0;
      unique case (size)
         MemByte: begin
            byteenable    = BYTEEN_B0 << addr_lo;
            wdata_aligned = {4{wdata[7:0]}};
         end
         MemHalf: begin
            byteenable    = addr_lo[1] ? BYTEEN_HI : BYTEEN_LO;
            wdata_aligned = {2{wdata[15:0]}};
            misalign      = addr_lo[0];
         end
         MemWord: begin
            byteenable = BYTEEN_ALL;
            misalign   = |addr_lo;
         end
         default: misalign = 1'b1;
      endcase
   end

   always_comb begin
      rd_byte   = readdata[{cap_lane, 3'b000} +: 8];
      rd_half   = cap_lane[1] ? readdata[31:16] : readdata[15:0];
      rdata_ext = readdata;
      unique case (cap_size)
         MemByte: rdata_ext = {{24{cap_signed & rd_byte[7]}}, rd_byte};
         MemHalf: rdata_ext = {{16{cap_signed & rd_half[15]}}, rd_half};
         default: rdata_ext = readdata;
      endcase
   end

endmodule

// File: rtl/mips_cpu_bus_initiator.sv
// Single-outstanding memory-bus initiator for the MIPS load/store path.
// Misaligned or reserved-size requests complete with resp_err, bus untouched.
module mips_cpu_bus_initiator
   import mips_cpu_bus_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          resp_valid,
   output logic          resp_err,
   output logic [31:0]   resp_rdata,
   mips_cpu_bus_if.master bus
);

   bus_state_t  state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [3:0]  be_q;
   mem_size_t   size_q;
   logic        sgn_q;
   logic [1:0]  lane_q;
   logic        read_q;
   logic        write_q;
   logic        valid_q;
   logic        err_q;

   logic [3:0]  req_be;
   logic [31:0] req_wdata_al;
   logic        req_misalign;
   logic [31:0] rd_ext;

   mips_cpu_bus_lane u_lane (
      .size          (mem_size_t'(req_size)),
      .addr_lo       (req_addr[1:0]),
      .wdata         (req_wdata),
      .byteenable    (req_be),
      .wdata_aligned (req_wdata_al),
      .misalign      (req_misalign),
      .cap_size      (size_q),
      .cap_lane      (lane_q),
      .cap_signed    (sgn_q),
      .readdata      (bus.readdata),
      .rdata_ext     (rd_ext)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= BYTEEN_NONE;
         size_q  <= MemByte;
         sgn_q   <= 1'b0;
         lane_q  <= 2'b00;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  if (req_misalign) begin
                     err_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= StResp;
                  end else begin
                     addr_q  <= word_addr(req_addr);
                     be_q    <= req_be;
                     wdata_q <= req_wdata_al;
                     size_q  <= mem_size_t'(req_size);
                     sgn_q   <= req_signed;
                     lane_q  <= req_addr[1:0];
                     if (req_write) begin
                        write_q <= 1'b1;
                        state_q <= StWrReq;
                     end else begin
                        read_q  <= 1'b1;
                        state_q <= StRdReq;
                     end
                  end
               end
            end
            StRdReq: begin
               if (!bus.waitrequest) begin
                  read_q  <= 1'b0;
                  state_q <= StRdCap;
               end
            end
            // readdata is valid in the cycle after the completing edge
            StRdCap: begin
               rdata_q <= rd_ext;
               valid_q <= 1'b1;
               state_q <= StResp;
            end
            StWrReq: begin
               if (!bus.waitrequest) begin
                  write_q <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= StResp;
               end
            end
            StResp: begin
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready      = (state_q == StIdle);
   assign resp_valid     = valid_q;
   assign resp_err       = err_q;
   assign resp_rdata     = rdata_q;
   assign bus.address    = addr_q;
   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.byteenable = be_q;
   assign bus.writedata  = wdata_q;

   a_no_dual_strobe : assert property (@(posedge clk) disable iff (!reset_n)
      !(read_q && write_q));

   a_resp_single : assert property (@(posedge clk) disable iff (!reset_n)
      valid_q |=> !valid_q);

endmodule

// File: tb/tb_mips_cpu_bus_initiator.sv
// Randomized bench for mips_cpu_bus_initiator with a request-level reference
// model, a waitrequest-driving memory slave and directed literal checks.
module tb_mips_cpu_bus_initiator;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   mips_cpu_bus_if bif ();

   mips_cpu_bus_initiator dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .bus        (bif)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];

   bit rand_wait = 0;
   int force_stall = 0;

   int          n_resp = 0;
   logic [31:0] last_addr, last_wdata, last_rdata;
   logic [3:0]  last_be;
   bit          last_err, last_wr, last_saw;
   int          last_lat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   // Memory slave: completes on an edge with strobe high and waitrequest low.
   initial begin : slave
      logic [31:0] w;
      bif.readdata = '0;
      forever begin
         @(posedge clk);
         if (bif.read && !bif.waitrequest) begin
            w = mem[bif.address[5:2]];
            for (int i = 0; i < 4; i++) if (!bif.byteenable[i]) w[8*i +: 8] = 8'h00;
            bif.readdata <= w;
         end else begin
            bif.readdata <= $urandom;
         end
         if (bif.write && !bif.waitrequest) begin
            w = mem[bif.address[5:2]];
            for (int i = 0; i < 4; i++)
               if (bif.byteenable[i]) w[8*i +: 8] = bif.writedata[8*i +: 8];
            mem[bif.address[5:2]] = w;
         end
      end
   end

   // Reference model and per-cycle compare, sampled on the falling edge.
   initial begin : compare
      bit          active, done, is_load, is_store, is_err, e_sgn;
      bit          exp_valid, strobe_r, strobe_w, up_strobe;
      int          t, resp_t, nb, lane, idx;
      logic [31:0] e_addr, e_wdata, exp_rd;
      logic [3:0]  e_be;
      longint      v, m;
      active = 0;
      done   = 0;
      bif.waitrequest = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            active = 0;
         end else if (active) begin
            t++;
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            strobe_r = is_load && !done;
            strobe_w = is_store && !done;
            chk("read", {31'b0, bif.read}, {31'b0, strobe_r});
            chk("write", {31'b0, bif.write}, {31'b0, strobe_w});
            if (bif.read || bif.write) last_saw = 1;
            if (strobe_r || strobe_w) begin
               chk("address", bif.address, e_addr & 32'hFFFF_FFFC);
               chk("byteenable", {28'b0, bif.byteenable}, {28'b0, e_be});
               if (strobe_w) chk("writedata", bif.writedata, e_wdata);
               if (t == 1) begin
                  last_addr  = bif.address;
                  last_be    = bif.byteenable;
                  last_wdata = bif.writedata;
                  last_wr    = bif.write;
               end
            end
            exp_valid = (done || is_err) && (t == resp_t);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
               idx = int'(e_addr[5:2]);
               exp_rd = '0;
               m = (longint'(1) << (8 * nb)) - 1;
               if (is_load) begin
                  v = (longint'(ref_mem[idx]) >> (8 * lane)) & m;
                  if (e_sgn && nb < 4 && v > (m >> 1)) v = v - (m + 1);
                  exp_rd = v[31:0];
               end
               if (is_store) begin
                  v = (longint'(ref_mem[idx]) & ~(m << (8 * lane)))
                      | ((longint'(e_wdata) << (8 * lane)) & (m << (8 * lane)));
                  ref_mem[idx] = v[31:0];
               end
               chk("resp_err", {31'b0, resp_err}, {31'b0, is_err});
               chk("resp_rdata", resp_rdata, exp_rd);
               last_rdata = resp_rdata;
               last_err   = resp_err;
               last_lat   = t;
               n_resp++;
               active = 0;
            end
         end else begin
            chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
            chk("idle_strobe", {30'b0, bif.read, bif.write}, 32'd0);
            chk("idle_resp", {31'b0, resp_valid}, 32'd0);
            if (req_valid) begin
               active   = 1;
               done     = 0;
               t        = 0;
               last_saw = 0;
               nb       = 1 << req_size;
               lane     = int'(req_addr[1:0]);
               e_addr   = req_addr;
               e_sgn    = req_signed;
               is_err   = (req_size == 2'b11) || ((lane % nb) != 0);
               is_load  = !is_err && !req_write;
               is_store = !is_err && req_write;
               resp_t   = is_err ? 1 : 0;
               e_be     = 4'(((1 << nb) - 1) << lane);
               if (nb == 1)      e_wdata = req_wdata[7:0] * 32'h0101_0101;
               else if (nb == 2) e_wdata = req_wdata[15:0] * 32'h0001_0001;
               else              e_wdata = req_wdata;
            end
         end
         up_strobe = reset_n && active && !done && !is_err && t >= 1;
         if (force_stall > 0 && up_strobe) begin
            bif.waitrequest = 1'b1;
            force_stall--;
         end else if (force_stall > 0) bif.waitrequest = 1'b0;
         else if (rand_wait) bif.waitrequest = ($urandom_range(0, 9) < 4);
         else bif.waitrequest = 1'b0;
         if (up_strobe && !bif.waitrequest) begin
            done   = 1;
            resp_t = t + (is_load ? 2 : 1);
         end
      end
   end

   task automatic start_req(input bit w, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
   endtask

   task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
      int n0;
      n0 = n_resp;
      @(posedge clk);
      #1;
      start_req(w, sz, sg, a, d);
      for (int i = 0; i < 200 && n_resp == n0; i++) begin
         @(posedge clk);
         #1;
      end
      if (n_resp == n0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no response expected one within 200 cycles");
      end
      req_valid = 1'b0;
   endtask

   initial begin : driver
      int n0;
      logic [1:0]  sz;
      logic [31:0] a;
      reset_n    = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[1] = 32'h8899_AABB;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      #1 reset_n = 1'b0;
      #2;
      chk("rst_strobes", {28'b0, bif.read, bif.write, resp_valid, resp_err}, 32'd0);
      chk("rst_address", bif.address, 32'd0);
      chk("rst_byteenable", {28'b0, bif.byteenable}, 32'd0);
      chk("rst_writedata", bif.writedata, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      #20 reset_n = 1'b1;
      @(posedge clk);
      #1 chk("rst_ready", {31'b0, req_ready}, 32'd1);

      do_req(1'b0, 2'b10, 1'b0, 32'hBFC0_0004, 32'h0);
      chk("wl_addr", last_addr, 32'hBFC0_0004);
      chk("wl_be", {28'b0, last_be}, 32'hF);
      chk("wl_rdata", last_rdata, 32'h8899_AABB);
      chk("wl_lat", last_lat, 32'd3);

      do_req(1'b0, 2'b00, 1'b1, 32'hBFC0_0007, 32'h0);
      chk("sb_be", {28'b0, last_be}, 32'h8);
      chk("sb_rdata", last_rdata, 32'hFFFF_FF88);
      do_req(1'b0, 2'b00, 1'b0, 32'hBFC0_0007, 32'h0);
      chk("ub_rdata", last_rdata, 32'h0000_0088);

      do_req(1'b1, 2'b01, 1'b0, 32'hBFC0_0006, 32'h0000_1234);
      chk("hs_write", {31'b0, last_wr}, 32'd1);
      chk("hs_be", {28'b0, last_be}, 32'hC);
      chk("hs_wdata", last_wdata, 32'h1234_1234);
      chk("hs_mem", mem[1], 32'h1234_AABB);
      chk("hs_lat", last_lat, 32'd2);

      force_stall = 5;
      do_req(1'b0, 2'b10, 1'b0, 32'hBFC0_0004, 32'h0);
      chk("stall_lat", last_lat, 32'd8);
      chk("stall_rdata", last_rdata, 32'h1234_AABB);

      do_req(1'b0, 2'b10, 1'b0, 32'hBFC0_0005, 32'h0);
      chk("mis_err", {31'b0, last_err}, 32'd1);
      chk("mis_lat", last_lat, 32'd1);
      chk("mis_rdata", last_rdata, 32'd0);
      chk("mis_strobe", {31'b0, last_saw}, 32'd0);
      do_req(1'b1, 2'b11, 1'b0, 32'hBFC0_0004, 32'hDEAD_BEEF);
      chk("rsv_err", {31'b0, last_err}, 32'd1);
      chk("rsv_lat", last_lat, 32'd1);
      chk("rsv_strobe", {31'b0, last_saw}, 32'd0);

      // Reset while a stalled read is on the bus.
      n0 = n_resp;
      force_stall = 10;
      @(posedge clk);
      #1 start_req(1'b0, 2'b10, 1'b0, 32'hBFC0_0008, 32'h0);
      for (int i = 0; i < 20 && !bif.read; i++) begin
         @(posedge clk);
         #1;
      end
      chk("abort_read_before", {31'b0, bif.read}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_read_drop", {31'b0, bif.read}, 32'd0);
      chk("abort_resp", {31'b0, resp_valid}, 32'd0);
      req_valid   = 1'b0;
      force_stall = 0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_resp", n_resp - n0, 32'd0);
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      do_req(1'b0, 2'b10, 1'b0, 32'hBFC0_0004, 32'h0);
      chk("post_rst_rdata", last_rdata, 32'h1234_AABB);
      chk("post_rst_err", {31'b0, last_err}, 32'd0);

      rand_wait = 1;
      for (int k = 0; k < 300; k++) begin
         n0 = $urandom_range(0, 15);
         sz = (n0 < 5) ? 2'b00 : (n0 < 10) ? 2'b01 : (n0 < 15) ? 2'b10 : 2'b11;
         a  = 32'hBFC0_0000 | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_cpu_bus_initiator.md
# mips_cpu_bus_initiator

Memory-bus initiator between the MIPS CPU core's load/store datapath and the 32-bit word-addressed memory bus (address/read/write/waitrequest/byteenable/readdata/writedata). Accepts one sized request at a time (byte, half, word; signed or unsigned), issues the word-aligned bus transfer with lane-aligned byteenable and writedata, holds it under waitrequest, and returns the extended read result or a write completion. Misaligned requests are rejected without touching the bus.

## Interface
- No parameters.
- clk  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  initiator idle; request accepted on posedge when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  mem_size_t: 00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result (ignored for word and store)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned or reserved size
- resp_rdata  out  32  extended load data; 0 for stores and errors
- address  out  32  {req_addr[31:2], 2'b00}
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- waitrequest  in  1  bus stall; transfer completes at a posedge where read/write is high and waitrequest is low
- byteenable  out  4  active lanes
- writedata  out  32  lane-aligned store data
- readdata  in  32  valid in the cycle after the completing edge; disabled lanes read as 0

## Operation
- States: IDLE, RD_REQ, RD_CAP, WR_REQ, RESP.
- IDLE: req_ready=1. On accept: misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 11) → RESP with resp_err=1, no strobe. Otherwise latch address/byteenable/writedata/size/signed/lane; load → RD_REQ, store → WR_REQ.
- RD_REQ: read=1. Edge with waitrequest=0 → RD_CAP; otherwise stay.
- RD_CAP: read=0; extract lane from readdata (byte: lane addr[1:0]; half: lane pair addr[1]), zero- or sign-extend, register into resp_rdata → RESP.
- WR_REQ: write=1. Edge with waitrequest=0 → RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0 → IDLE.
- byteenable: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
- writedata: byte req_wdata[7:0] replicated into all 4 lanes; half req_wdata[15:0] replicated into both halves; word unchanged.
- read and write are never asserted together; at most one outstanding transfer.

## Timing
- Reset (async, immediate): state IDLE; read, write, resp_valid, resp_err = 0; address, byteenable, writedata, resp_rdata = 0; req_ready = 1 once reset_n is high.
- Reset mid-transfer drops the strobe asynchronously; no response is issued for the aborted request.
- address, byteenable, writedata stable from the first strobe cycle until the completing edge.
- Load latency with waitrequest=0: accept edge → RD_REQ (cycle 1) → RD_CAP (cycle 2) → resp_valid (cycle 3). Each stalled edge adds one cycle.
- Store latency: strobe in cycle 1 → resp_valid in cycle 2, plus stalls.
- Error: resp_valid in cycle 1 after accept.
- Next request is accepted no earlier than the cycle after RESP.
- A req_valid arriving while busy is ignored (req_ready=0); the core holds it.
- waitrequest is don't-care when no strobe is asserted.

## Structure
- mips_cpu_bus_pkg: mem_size_t enum, bus_state_t enum, BYTEEN_* constants.
- Sub-module mips_cpu_bus_lane (combinational): size + addr[1:0] → byteenable, aligned writedata, misalign flag; readdata + lane + signed → extended result.
- FSM and registers live in mips_cpu_bus_initiator.

## Test plan
- Word load at 0xBFC00004 (memory 0x8899AABB), waitrequest=0: address 0xBFC00004, byteenable 1111, resp_rdata 0x8899AABB three cycles after accept.
- Signed byte load at 0xBFC00007 from the same word: byteenable 1000, resp_rdata 0xFFFFFF88. Unsigned: 0x00000088.
- Half store of 0x1234 at 0xBFC00006: write=1, byteenable 1100, writedata 0x12341234; memory word becomes 0x1234AABB; resp_valid in cycle 2.
- waitrequest held high for 5 edges during a read: read stays high, address stable, no resp_valid; response follows the first low edge.
- Word load at 0xBFC00005 and size 11: no strobe, resp_valid and resp_err=1 in cycle 1, resp_rdata 0.
- reset_n pulled low during RD_REQ: read drops immediately, no resp_valid; after release, req_ready=1 and a new load completes normally.
